// File: rtl/shape_fetch.sv
// Burst reader for fixed-stride shape records: issues FIELDS reads per record back to back,
// captures them after RD_LAT cycles and presents each decoded record on a valid/ready port.
module shape_fetch #(
  parameter int DATAB  = 3,
  parameter int FIELDS = 5,
  parameter int RD_LAT = 1,
  parameter int CORDW  = 9,
  parameter int ADDRW  = 20,
  parameter int DATAW  = 12,
  parameter int NUMW   = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [NUMW-1:0]  id_first,
  input  logic [NUMW-1:0]  count,
  input  logic [ADDRW-1:0] ram_address_offset,
  output logic [ADDRW-1:0] ram_address,
  output logic             ram_enable,
  input  logic [DATAW-1:0] ram_data,
  output logic             busy,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [NUMW-1:0]  rec_id,
  output logic [DATAW-1:0] ty,
  output logic [CORDW-1:0] x,
  output logic [CORDW-1:0] y,
  output logic [DATAW-1:0] size,
  output logic [DATAW-1:0] rotate,
  output logic             done
);

  localparam int PTRW = (DATAB > 0) ? DATAB : 1;
  localparam logic [PTRW-1:0] LAST_PTR = PTRW'(FIELDS - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, PRESENT, FINISH} state_t;

  state_t           state_q, state_d;
  logic [NUMW-1:0]  id_q, id_d;
  logic [NUMW-1:0]  cnt_q, cnt_d;
  logic [ADDRW-1:0] off_q, off_d;
  logic [PTRW-1:0]  ptr_q, ptr_d;
  logic [DATAW-1:0] ty_q, ty_d, size_q, size_d, rot_q, rot_d;
  logic [CORDW-1:0] x_q, x_d, y_q, y_d;

  logic             pipe_vld_q [RD_LAT];
  logic             pipe_vld_d [RD_LAT];
  logic [PTRW-1:0]  pipe_idx_q [RD_LAT];
  logic [PTRW-1:0]  pipe_idx_d [RD_LAT];

  logic             issue;
  logic             cap_vld;
  logic [PTRW-1:0]  cap_idx;
  logic             clr_fields;
  logic [ADDRW-1:0] id_ext;

  assign issue   = (state_q == ISSUE);
  assign cap_vld = pipe_vld_q[RD_LAT-1];
  assign cap_idx = pipe_idx_q[RD_LAT-1];
  assign id_ext  = ADDRW'(id_q);

  // The tag pipeline travels alongside each read so the field index is known when data lands.
  always_comb begin
    pipe_vld_d[0] = issue;
    pipe_idx_d[0] = ptr_q;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_idx_d[i] = pipe_idx_q[i-1];
    end
  end

  always_comb begin
    // NOTE: every *_d takes its hold value first, so no branch below can infer a latch.
    state_d    = state_q;
    id_d       = id_q;
    cnt_d      = cnt_q;
    off_d      = off_q;
    ptr_d      = ptr_q;
    ty_d       = ty_q;
    x_d        = x_q;
    y_d        = y_q;
    size_d     = size_q;
    rot_d      = rot_q;
    clr_fields = 1'b0;

    if (cap_vld) begin
      case (int'(cap_idx))
        0:       ty_d   = ram_data;
        1:       x_d    = CORDW'(ram_data);
        2:       y_d    = CORDW'(ram_data);
        3:       size_d = ram_data;
        4:       rot_d  = ram_data;
        default: ;
      endcase
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          if (count == '0) begin
            state_d = FINISH;
          end else begin
            id_d       = id_first;
            cnt_d      = count;
            off_d      = ram_address_offset;
            ptr_d      = '0;
            clr_fields = 1'b1;
            state_d    = ISSUE;
          end
        end
      end
      ISSUE: begin
        ptr_d = ptr_q + PTRW'(1);
        if (ptr_q == LAST_PTR) state_d = WAIT;
      end
      WAIT: begin
        if (cap_vld && (cap_idx == LAST_PTR)) state_d = PRESENT;
      end
      PRESENT: begin
        if (rec_ready) begin
          if (cnt_q == NUMW'(1)) begin
            state_d = FINISH;
          end else begin
            id_d       = id_q + NUMW'(1);
            cnt_d      = cnt_q - NUMW'(1);
            ptr_d      = '0;
            clr_fields = 1'b1;
            state_d    = ISSUE;
          end
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (clr_fields) begin
      ty_d   = '0;
      x_d    = '0;
      y_d    = '0;
      size_d = '0;
      rot_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values regardless of order.
    if (!rst_n) begin
      state_q <= IDLE;
      id_q    <= '0;
      cnt_q   <= '0;
      off_q   <= '0;
      ptr_q   <= '0;
      ty_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      size_q  <= '0;
      rot_q   <= '0;
      // NOTE: the tag pipeline is reset (unlike a data RAM) so reads in flight are dropped.
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_vld_q[i] <= 1'b0;
        pipe_idx_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      off_q   <= off_d;
      ptr_q   <= ptr_d;
      ty_q    <= ty_d;
      x_q     <= x_d;
      y_q     <= y_d;
      size_q  <= size_d;
      rot_q   <= rot_d;
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_vld_q[i] <= pipe_vld_d[i];
        pipe_idx_q[i] <= pipe_idx_d[i];
      end
    end
  end

  assign ram_enable  = issue;
  assign ram_address = issue ? (off_q + (id_ext << DATAB) + ADDRW'(ptr_q)) : '0;
  assign busy        = (state_q != IDLE);
  assign rec_valid   = (state_q == PRESENT);
  assign done        = (state_q == FINISH);
  assign rec_id      = id_q;
  assign ty          = ty_q;
  assign x           = x_q;
  assign y           = y_q;
  assign size        = size_q;
  assign rotate      = rot_q;

endmodule

// File: tb/tb_shape_fetch.sv
// Scoreboard bench for shape_fetch: two instances (5 fields / latency 1 and 3 fields / latency 3)
// driven with directed and random bursts, checked against an arithmetic record model.
module tb_shape_fetch;

  localparam int F0 = 5, L0 = 1, F1 = 3, L1 = 3;
  localparam int STRIDE = 8;

  typedef struct packed {
    logic [11:0] id;
    logic [11:0] ty;
    logic [8:0]  x;
    logic [8:0]  y;
    logic [11:0] size;
    logic [11:0] rotate;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_s    [2];
  logic [11:0] id_first_s [2];
  logic [11:0] count_s    [2];
  logic [19:0] off_s      [2];
  logic [19:0] addr_s     [2];
  logic        en_s       [2];
  logic [11:0] data_s     [2];
  logic        busy_s     [2];
  logic        vld_s      [2];
  logic        rdy_s      [2];
  logic        done_s     [2];
  logic [11:0] rid_s      [2];
  logic [11:0] ty_s       [2];
  logic [8:0]  x_s        [2];
  logic [8:0]  y_s        [2];
  logic [11:0] size_s     [2];
  logic [11:0] rot_s      [2];

  always #5 clk = ~clk;

  shape_fetch #(.DATAB(3), .FIELDS(F0), .RD_LAT(L0), .CORDW(9), .ADDRW(20), .DATAW(12), .NUMW(12)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .id_first(id_first_s[0]), .count(count_s[0]),
    .ram_address_offset(off_s[0]), .ram_address(addr_s[0]), .ram_enable(en_s[0]), .ram_data(data_s[0]),
    .busy(busy_s[0]), .rec_valid(vld_s[0]), .rec_ready(rdy_s[0]), .rec_id(rid_s[0]), .ty(ty_s[0]),
    .x(x_s[0]), .y(y_s[0]), .size(size_s[0]), .rotate(rot_s[0]), .done(done_s[0]));

  shape_fetch #(.DATAB(3), .FIELDS(F1), .RD_LAT(L1), .CORDW(9), .ADDRW(20), .DATAW(12), .NUMW(12)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .id_first(id_first_s[1]), .count(count_s[1]),
    .ram_address_offset(off_s[1]), .ram_address(addr_s[1]), .ram_enable(en_s[1]), .ram_data(data_s[1]),
    .busy(busy_s[1]), .rec_valid(vld_s[1]), .rec_ready(rdy_s[1]), .rec_id(rid_s[1]), .ty(ty_s[1]),
    .x(x_s[1]), .y(y_s[1]), .size(size_s[1]), .rotate(rot_s[1]), .done(done_s[1]));

  // Shape RAM: a fixed hash of the address, with directed overrides.
  logic [11:0] ram_ovr [int];

  function automatic logic [11:0] ram_word(input logic [19:0] a);
    if (ram_ovr.exists(int'(a))) return ram_ovr[int'(a)];
    return 12'((32'(a) * 32'd40503) ^ (32'(a) >> 5));
  endfunction

  logic [11:0] rd0_q;
  logic [11:0] rd1_q [3];

  always @(posedge clk) begin
    rd0_q    <= en_s[0] ? ram_word(addr_s[0]) : 12'($urandom);
    rd1_q[0] <= en_s[1] ? ram_word(addr_s[1]) : 12'($urandom);
    rd1_q[1] <= rd1_q[0];
    rd1_q[2] <= rd1_q[1];
  end

  assign data_s[0] = rd0_q;
  assign data_s[1] = rd1_q[2];

  // Scoreboard state
  rec_t        rq0[$], rq1[$];
  logic [19:0] aq0[$], aq1[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int fld(input int k);
    return (k == 0) ? F0 : F1;
  endfunction

  function automatic int lat(input int k);
    return (k == 0) ? L0 : L1;
  endfunction

  // Reference model: record r of a burst lives at offset + id*stride, fields beyond FIELDS read as 0.
  task automatic model_push(input int k, input logic [11:0] idf, input logic [11:0] cnt, input logic [19:0] off);
    for (int r = 0; r < int'(cnt); r++) begin
      rec_t        e;
      logic [11:0] id;
      logic [19:0] base;
      logic [11:0] w [5];
      id   = 12'((int'(idf) + r) % 4096);
      base = 20'((int'(off) + int'(id) * STRIDE) % (1 << 20));
      for (int f = 0; f < 5; f++) begin
        if (f < fld(k)) begin
          w[f] = ram_word(20'((int'(base) + f) % (1 << 20)));
          if (k == 0) aq0.push_back(20'((int'(base) + f) % (1 << 20)));
          else        aq1.push_back(20'((int'(base) + f) % (1 << 20)));
        end else begin
          w[f] = 12'd0;
        end
      end
      e = '{id: id, ty: w[0], x: w[1][8:0], y: w[2][8:0], size: w[3], rotate: w[4]};
      if (k == 0) rq0.push_back(e);
      else        rq1.push_back(e);
    end
  endtask

  // Consumer ready
  bit hold [2];
  bit rand_rdy = 1'b0;

  initial begin
    rdy_s[0] = 1'b1;
    rdy_s[1] = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++)
        rdy_s[k] = hold[k] ? 1'b0 : (rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
    end
  end

  // Monitor
  int   cyc = 0;
  int   done_cnt [2];
  int   acc_cnt  [2];
  int   t_iss    [2];
  int   run      [2];
  int   last_hs  [2];
  bit   zero_burst [2];
  bit   p_en [2], p_vld [2], p_rdy [2], p_done [2];
  rec_t snap [2];

  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      rec_t        cur;
      rec_t        e;
      logic [19:0] ea;
      bit          have;
      cur = '{id: rid_s[k], ty: ty_s[k], x: x_s[k], y: y_s[k], size: size_s[k], rotate: rot_s[k]};
      if (!rst_n) begin
        p_en[k] = 1'b0; p_vld[k] = 1'b0; p_rdy[k] = 1'b0; p_done[k] = 1'b0; run[k] = 0;
      end else begin
        if (en_s[k]) begin
          have = 1'b0;
          if (k == 0 && aq0.size() > 0) begin ea = aq0.pop_front(); have = 1'b1; end
          if (k == 1 && aq1.size() > 0) begin ea = aq1.pop_front(); have = 1'b1; end
          if (have) check($sformatf("ram_address_i%0d", k), addr_s[k], ea);
          else      check($sformatf("unexpected_read_i%0d", k), en_s[k], 1'b0);
          if (!p_en[k]) t_iss[k] = cyc;
          run[k]++;
        end else if (p_en[k]) begin
          check($sformatf("issue_run_i%0d", k), run[k], fld(k));
          run[k] = 0;
        end
        if (vld_s[k]) check($sformatf("enable_while_present_i%0d", k), en_s[k], 1'b0);
        if (vld_s[k] && !p_vld[k])
          check($sformatf("valid_latency_i%0d", k), cyc - t_iss[k], fld(k) + lat(k));
        if (p_vld[k] && !p_rdy[k]) begin
          check($sformatf("hold_valid_i%0d", k), vld_s[k], 1'b1);
          check($sformatf("hold_fields_i%0d", k), cur, snap[k]);
        end
        if (vld_s[k] && rdy_s[k]) begin
          have = 1'b0;
          if (k == 0 && rq0.size() > 0) begin e = rq0.pop_front(); have = 1'b1; end
          if (k == 1 && rq1.size() > 0) begin e = rq1.pop_front(); have = 1'b1; end
          if (have) check($sformatf("record_i%0d", k), cur, e);
          else      check($sformatf("unexpected_record_i%0d", k), vld_s[k], 1'b0);
          last_hs[k] = cyc;
          acc_cnt[k]++;
        end
        if (done_s[k]) begin
          done_cnt[k]++;
          check($sformatf("done_busy_i%0d", k), busy_s[k], 1'b1);
          check($sformatf("done_single_i%0d", k), p_done[k], 1'b0);
          if (!zero_burst[k]) check($sformatf("done_after_xfer_i%0d", k), cyc - last_hs[k], 1);
        end
        p_en[k]   = en_s[k];
        p_vld[k]  = vld_s[k];
        p_rdy[k]  = rdy_s[k];
        p_done[k] = done_s[k];
        snap[k]   = cur;
      end
    end
  end

  function automatic int pending(input int k);
    return (k == 0) ? (rq0.size() + aq0.size()) : (rq1.size() + aq1.size());
  endfunction

  task automatic check_zero(input int k, input string tag);
    check({tag, "_ram_enable"}, en_s[k], 1'b0);
    check({tag, "_ram_address"}, addr_s[k], 20'd0);
    check({tag, "_busy"}, busy_s[k], 1'b0);
    check({tag, "_rec_valid"}, vld_s[k], 1'b0);
    check({tag, "_done"}, done_s[k], 1'b0);
    check({tag, "_rec_id"}, rid_s[k], 12'd0);
    check({tag, "_fields"}, {ty_s[k], x_s[k], y_s[k], size_s[k], rot_s[k]}, 54'd0);
  endtask

  task automatic burst(input int k, input logic [11:0] idf, input logic [11:0] cnt,
                       input logic [19:0] off, input bit poke, input int hold_cyc);
    int d0, n, held;
    @(posedge clk);
    #1;
    d0            = done_cnt[k];
    zero_burst[k] = (cnt == 12'd0);
    hold[k]       = (hold_cyc > 0);
    model_push(k, idf, cnt, off);
    start_s[k]    = 1'b1;
    id_first_s[k] = idf;
    count_s[k]    = cnt;
    off_s[k]      = off;
    @(posedge clk);
    #1;
    start_s[k]    = 1'b0;
    id_first_s[k] = 12'($urandom);
    count_s[k]    = 12'($urandom);
    off_s[k]      = 20'($urandom);
    check("first_cycle_enable", en_s[k], cnt != 12'd0);
    check("first_cycle_done", done_s[k], cnt == 12'd0);
    check("first_cycle_busy", busy_s[k], 1'b1);
    n    = 0;
    held = 0;
    while (done_cnt[k] == d0 && n < 3000) begin
      if (poke && n == 2) begin
        start_s[k]    = 1'b1;
        count_s[k]    = 12'd5;
        id_first_s[k] = 12'h3C3;
      end
      if (poke && n == 3) start_s[k] = 1'b0;
      if (hold[k] && vld_s[k]) begin
        held++;
        if (held >= hold_cyc) hold[k] = 1'b0;
      end
      @(posedge clk);
      #1;
      n++;
    end
    hold[k] = 1'b0;
    check("burst_done_count", done_cnt[k] - d0, 1);
    check("burst_scoreboard_drained", pending(k), 0);
  endtask

  task automatic reset_mid();
    int n, d0, a0;
    @(posedge clk);
    #1;
    d0            = done_cnt[0];
    a0            = acc_cnt[0];
    zero_burst[0] = 1'b0;
    model_push(0, 12'h040, 12'd3, 20'h03000);
    start_s[0]    = 1'b1;
    id_first_s[0] = 12'h040;
    count_s[0]    = 12'd3;
    off_s[0]      = 20'h03000;
    @(posedge clk);
    #1;
    start_s[0] = 1'b0;
    n = 0;
    while (!(acc_cnt[0] == a0 + 1 && en_s[0]) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("reached_second_record_issue", en_s[0], 1'b1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_zero(0, "mid_reset");
    rq0.delete();
    aq0.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("no_done_after_reset", done_cnt[0] - d0, 0);
    check("no_record_after_reset", acc_cnt[0] - a0, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      start_s[k]    = 1'b0;
      id_first_s[k] = '0;
      count_s[k]    = '0;
      off_s[k]      = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    check_zero(0, "reset_i0");
    check_zero(1, "reset_i1");
    rst_n = 1'b1;

    // Single record; neighbouring word 0x115 must never be read
    ram_ovr[32'h110] = 12'd5;
    ram_ovr[32'h111] = 12'd40;
    ram_ovr[32'h112] = 12'd60;
    ram_ovr[32'h113] = 12'd9;
    ram_ovr[32'h114] = 12'd3;
    ram_ovr[32'h115] = 12'h777;
    burst(0, 12'd2, 12'd1, 20'h00100, 1'b0, 0);

    // Three-field instance with all-ones data
    ram_ovr[32'h2080] = 12'hFFF;
    ram_ovr[32'h2081] = 12'hFFF;
    ram_ovr[32'h2082] = 12'hFFF;
    burst(1, 12'h010, 12'd1, 20'h02000, 1'b0, 0);

    burst(1, 12'd0, 12'd3, 20'h50000, 1'b0, 0);
    burst(0, 12'd0, 12'd3, 20'h60000, 1'b0, 0);
    burst(0, 12'd7, 12'd0, 20'h00000, 1'b0, 0);
    burst(1, 12'd9, 12'd0, 20'h00040, 1'b0, 0);
    burst(0, 12'h123, 12'd2, 20'h12340, 1'b1, 0);
    burst(1, 12'h321, 12'd2, 20'h43210, 1'b1, 0);
    burst(0, 12'h0A0, 12'd2, 20'h08000, 1'b0, 10);
    burst(1, 12'h0B0, 12'd2, 20'h09000, 1'b0, 10);
    burst(0, 12'hFFF, 12'd2, 20'hFFFF0, 1'b0, 0);
    burst(1, 12'hFFF, 12'd2, 20'hFFFF8, 1'b0, 0);

    reset_mid();
    burst(0, 12'h055, 12'd2, 20'h04000, 1'b0, 0);

    rand_rdy = 1'b1;
    repeat (24) begin
      int          k;
      logic [11:0] idf, cnt;
      logic [19:0] off;
      bit          poke;
      int          hc;
      k    = int'($urandom_range(0, 1));
      idf  = 12'($urandom);
      cnt  = 12'($urandom_range(0, 4));
      off  = 20'($urandom);
      poke = 1'($urandom_range(0, 1));
      hc   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0;
      burst(k, idf, cnt, off, poke, hc);
    end

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
